// File: rtl/bus_controller_if.sv
// bus_controller_if: shared PE bus between the processing elements (master) and the bus controller (slave).
interface bus_controller_if #(parameter int NUM_PE = 4);
  logic [NUM_PE-1:0] bus_request, grant, exec_done_mask;
  logic [31:0] mem_addressBus, result_outBus, PCoutBus, AmuxBus, BmuxBus, memData;
  logic [4:0] rs1OutBus, rs2OutBus, rdOutBus;
  logic reg_selectBus, mem_readBus, mem_writeBus, rd_writeBus, read_enBus, execution_completeBus;
  logic mem_ackBus, data_ReadyBus, bus_err, all_done;
  modport master (
    output bus_request, mem_addressBus, result_outBus, PCoutBus, rs1OutBus, rs2OutBus, rdOutBus,
           reg_selectBus, mem_readBus, mem_writeBus, rd_writeBus, read_enBus, execution_completeBus,
    input  grant, AmuxBus, BmuxBus, memData, mem_ackBus, data_ReadyBus, bus_err, exec_done_mask, all_done
  );
  modport slave (
    input  bus_request, mem_addressBus, result_outBus, PCoutBus, rs1OutBus, rs2OutBus, rdOutBus,
           reg_selectBus, mem_readBus, mem_writeBus, rd_writeBus, read_enBus, execution_completeBus,
    output grant, AmuxBus, BmuxBus, memData, mem_ackBus, data_ReadyBus, bus_err, exec_done_mask, all_done
  );
endinterface

// File: rtl/bus_controller.sv
// bus_controller: round-robin PE bus arbiter serving global memory and shared register file commands.
// Optional BUS_TIMEOUT_EN macro revokes idle grants after TIMEOUT_CYCLES and raises sticky timeout_err.
module bus_controller #(
  parameter int NUM_PE = 4,
  parameter int MEM_WORDS = 256,
  parameter int MEM_LATENCY = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic clk,
  input logic reset,
`ifdef BUS_TIMEOUT_EN
  output logic timeout_err,
`endif
  bus_controller_if.slave bus
);
  localparam int ADDR_W = $clog2(MEM_WORDS);
  localparam int PW = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  localparam int CW = $clog2(MEM_LATENCY + 1);
  typedef enum logic [2:0] {IDLE, GRANTED, MEM_WAIT, RESP, DRAIN} state_e;
  state_e state_q, state_d;
  logic [PW-1:0] gidx_q, gidx_d, ptr_q, ptr_d, pick;
  logic [NUM_PE-1:0] grant_q, grant_d, done_q, done_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d, mdata_q, mdata_d, a_q, a_d, b_q, b_d;
  logic wr_q, wr_d, oor_q, oor_d, ack_q, ack_d, rdy_q, rdy_d, err_q, err_d;
  logic rf_we, mem_we, strobe, oor, unused;
  logic [31:0] rf_q [32];
  logic [31:0] mem_q [MEM_WORDS];
`ifdef BUS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_q, to_d;
  logic terr_q, terr_d;
  assign timeout_err = terr_q;
`endif
  assign strobe = bus.mem_writeBus | bus.mem_readBus | bus.rd_writeBus | bus.read_enBus;
  assign oor = |bus.mem_addressBus[31:ADDR_W+2];
  assign unused = ^bus.mem_addressBus[1:0];
  // Descending scan so the nearest requester after the pointer wins.
  always_comb begin
    pick = ptr_q;
    for (int i = NUM_PE; i >= 1; i--)
      if (bus.bus_request[(int'(ptr_q) + i) % NUM_PE]) pick = PW'((int'(ptr_q) + i) % NUM_PE);
  end
  always_comb begin
    state_d = state_q;
    gidx_d = gidx_q;
    ptr_d = ptr_q;
    grant_d = grant_q;
    cnt_d = cnt_q;
    wr_d = wr_q;
    addr_d = addr_q;
    oor_d = oor_q;
    wdata_d = wdata_q;
    mdata_d = mdata_q;
    a_d = a_q;
    b_d = b_q;
    ack_d = 1'b0;
    rdy_d = 1'b0;
    err_d = 1'b0;
    rf_we = 1'b0;
    mem_we = 1'b0;
    done_d = done_q | ((state_q != IDLE && bus.execution_completeBus) ? grant_q : '0);
`ifdef BUS_TIMEOUT_EN
    to_d = '0;
    terr_d = terr_q;
`endif
    case (state_q)
      IDLE: if (|bus.bus_request) begin
        gidx_d = pick;
        grant_d = NUM_PE'(1) << pick;
        state_d = GRANTED;
      end
      GRANTED: if (bus.mem_writeBus || bus.mem_readBus) begin
        wr_d = bus.mem_writeBus;
        addr_d = bus.mem_addressBus[ADDR_W+1:2];
        oor_d = oor;
        wdata_d = bus.result_outBus;
        cnt_d = CW'(MEM_LATENCY);
        state_d = MEM_WAIT;
      end else if (bus.rd_writeBus) begin
        rf_we = bus.rdOutBus != 5'd0;
        ack_d = 1'b1;
        state_d = RESP;
      end else if (bus.read_enBus) begin
        a_d = bus.reg_selectBus ? rf_q[bus.rs1OutBus] : bus.PCoutBus;
        b_d = rf_q[bus.rs2OutBus];
        rdy_d = 1'b1;
        state_d = RESP;
      end else if (!bus.bus_request[gidx_q]) begin
        grant_d = '0;
        ptr_d = gidx_q;
        state_d = IDLE;
      end
`ifdef BUS_TIMEOUT_EN
      else if (to_q == TW'(TIMEOUT_CYCLES - 1)) begin
        grant_d = '0;
        ptr_d = gidx_q;
        terr_d = 1'b1;
        state_d = IDLE;
      end else to_d = to_q + 1'b1;
`endif
      MEM_WAIT: if (cnt_q == '0) begin
        mem_we = wr_q && !oor_q;
        mdata_d = oor_q ? '0 : (wr_q ? mdata_q : mem_q[addr_q]);
        ack_d = 1'b1;
        err_d = oor_q;
        state_d = RESP;
      end else cnt_d = cnt_q - 1'b1;
      RESP: state_d = DRAIN;
      default: state_d = strobe ? state_q : GRANTED;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      gidx_q <= '0;
      ptr_q <= PW'(NUM_PE - 1);
      grant_q <= '0;
      cnt_q <= '0;
      wr_q <= 1'b0;
      addr_q <= '0;
      oor_q <= 1'b0;
      wdata_q <= '0;
      mdata_q <= '0;
      a_q <= '0;
      b_q <= '0;
      ack_q <= 1'b0;
      rdy_q <= 1'b0;
      err_q <= 1'b0;
      done_q <= '0;
    end else begin
      state_q <= state_d;
      gidx_q <= gidx_d;
      ptr_q <= ptr_d;
      grant_q <= grant_d;
      cnt_q <= cnt_d;
      wr_q <= wr_d;
      addr_q <= addr_d;
      oor_q <= oor_d;
      wdata_q <= wdata_d;
      mdata_q <= mdata_d;
      a_q <= a_d;
      b_q <= b_d;
      ack_q <= ack_d;
      rdy_q <= rdy_d;
      err_q <= err_d;
      done_q <= done_d;
    end
  end
`ifdef BUS_TIMEOUT_EN
  always_ff @(posedge clk) begin
    to_q <= reset ? '0 : to_d;
    terr_q <= reset ? 1'b0 : terr_d;
  end
`endif
  always_ff @(posedge clk) begin
    if (reset) rf_q <= '{default: '0};
    else if (rf_we) rf_q[bus.rdOutBus] <= bus.result_outBus;
  end
  // Memory keeps its contents across reset; reset only blocks an in-flight write.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) mem_q[addr_q] <= wdata_q;
  end
  assign bus.grant = grant_q;
  assign bus.memData = mdata_q;
  assign bus.AmuxBus = a_q;
  assign bus.BmuxBus = b_q;
  assign bus.mem_ackBus = ack_q;
  assign bus.data_ReadyBus = rdy_q;
  assign bus.bus_err = err_q;
  assign bus.exec_done_mask = done_q;
  assign bus.all_done = &done_q;
endmodule

// File: tb/tb_bus_controller.sv
// tb_bus_controller: directed self-checking bench for bus_controller (NUM_PE=4, MEM_WORDS=256, MEM_LATENCY=2).
module tb_bus_controller;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  int acks, errs, ack_cyc, err_cyc;
  logic ack0, ack1, rdy0, rdy1;
`ifdef BUS_TIMEOUT_EN
  logic timeout_err;
`endif
  bus_controller_if #(.NUM_PE(4)) bus();
  bus_controller #(.NUM_PE(4), .MEM_WORDS(256), .MEM_LATENCY(2), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk),
    .reset(reset),
`ifdef BUS_TIMEOUT_EN
    .timeout_err(timeout_err),
`endif
    .bus(bus)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic run_mem(input logic wr, input logic [31:0] addr, input logic [31:0] data);
    bus.mem_writeBus = wr;
    bus.mem_readBus = !wr;
    bus.mem_addressBus = addr;
    bus.result_outBus = data;
    acks = 0; errs = 0; ack_cyc = 0; err_cyc = 0;
    step();
    bus.mem_writeBus = 0; bus.mem_readBus = 0; bus.rd_writeBus = 0;
    for (int i = 1; i <= 5; i++) begin
      step();
      if (bus.mem_ackBus) begin acks++; ack_cyc = i; end
      if (bus.bus_err) begin errs++; err_cyc = i; end
    end
  endtask
  task automatic run_reg(input logic wr, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic sel, input logic [31:0] data, input logic [31:0] pc);
    bus.rd_writeBus = wr;
    bus.read_enBus = !wr;
    bus.rdOutBus = rd; bus.rs1OutBus = rs1; bus.rs2OutBus = rs2;
    bus.reg_selectBus = sel; bus.result_outBus = data; bus.PCoutBus = pc;
    step();
    ack0 = bus.mem_ackBus; rdy0 = bus.data_ReadyBus;
    bus.rd_writeBus = 0; bus.read_enBus = 0;
    step();
    ack1 = bus.mem_ackBus; rdy1 = bus.data_ReadyBus;
    step();
  endtask
  task automatic test_reset();
    reset = 1;
    step(); step();
    reset = 0;
    checks++; if (bus.grant !== 4'b0000) begin errors++; $display("FAIL reset_grant got %b exp 0000", bus.grant); end
    checks++; if (bus.mem_ackBus !== 1'b0 || bus.data_ReadyBus !== 1'b0 || bus.bus_err !== 1'b0) begin errors++; $display("FAIL reset_pulses got %b%b%b exp 000", bus.mem_ackBus, bus.data_ReadyBus, bus.bus_err); end
    checks++; if (bus.exec_done_mask !== 4'b0000 || bus.all_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b/%b exp 0000/0", bus.exec_done_mask, bus.all_done); end
    checks++; if (bus.memData !== 32'h0 || bus.AmuxBus !== 32'h0 || bus.BmuxBus !== 32'h0) begin errors++; $display("FAIL reset_data got %h %h %h exp 0", bus.memData, bus.AmuxBus, bus.BmuxBus); end
  endtask
  task automatic test_arbitration();
    bus.bus_request = 4'b0101;
    step();
    checks++; if (bus.grant !== 4'b0001) begin errors++; $display("FAIL arb_first got %b exp 0001", bus.grant); end
    bus.bus_request = 4'b0100;
    step();
    checks++; if (bus.grant !== 4'b0000) begin errors++; $display("FAIL arb_release got %b exp 0000", bus.grant); end
    step();
    checks++; if (bus.grant !== 4'b0100) begin errors++; $display("FAIL arb_next got %b exp 0100", bus.grant); end
  endtask
  task automatic test_mem();
    run_mem(1, 32'h10, 32'h12345678);
    checks++; if (acks !== 1 || ack_cyc !== 3) begin errors++; $display("FAIL mem_write_ack got %0d@%0d exp 1@3", acks, ack_cyc); end
    checks++; if (errs !== 0) begin errors++; $display("FAIL mem_write_err got %0d exp 0", errs); end
    run_mem(0, 32'h10, 32'h0);
    checks++; if (acks !== 1 || ack_cyc !== 3) begin errors++; $display("FAIL mem_read_ack got %0d@%0d exp 1@3", acks, ack_cyc); end
    checks++; if (bus.memData !== 32'h12345678) begin errors++; $display("FAIL mem_read_data got %h exp 12345678", bus.memData); end
  endtask
  task automatic test_out_of_range();
    run_mem(1, 32'hDC, 32'h0BADF00D);
    run_mem(1, 32'hAABBCCDD, 32'hDEADBEEF);
    checks++; if (acks !== 1 || errs !== 1 || err_cyc !== ack_cyc) begin errors++; $display("FAIL oor_write_pulse got ack %0d err %0d@%0d exp 1 1@%0d", acks, errs, err_cyc, ack_cyc); end
    run_mem(0, 32'hAABBCCDD, 32'h0);
    checks++; if (bus.memData !== 32'h0 || errs !== 1) begin errors++; $display("FAIL oor_read got %h err %0d exp 00000000 err 1", bus.memData, errs); end
    run_mem(0, 32'hDC, 32'h0);
    checks++; if (bus.memData !== 32'h0BADF00D || errs !== 0) begin errors++; $display("FAIL oor_alias got %h err %0d exp 0badf00d err 0", bus.memData, errs); end
  endtask
  task automatic test_regs();
    run_reg(1, 5'd10, 5'd0, 5'd0, 1'b0, 32'hFACECAFE, 32'h0);
    checks++; if (ack0 !== 1'b1 || ack1 !== 1'b0 || rdy0 !== 1'b0) begin errors++; $display("FAIL rdw_ack got %b%b rdy %b exp 10 rdy 0", ack0, ack1, rdy0); end
    run_reg(0, 5'd0, 5'd10, 5'd0, 1'b1, 32'h0, 32'h0);
    checks++; if (bus.AmuxBus !== 32'hFACECAFE || bus.BmuxBus !== 32'h0) begin errors++; $display("FAIL read_regs got %h %h exp facecafe 00000000", bus.AmuxBus, bus.BmuxBus); end
    checks++; if (rdy0 !== 1'b1 || rdy1 !== 1'b0 || ack0 !== 1'b0) begin errors++; $display("FAIL read_ready got %b%b ack %b exp 10 ack 0", rdy0, rdy1, ack0); end
    run_reg(0, 5'd0, 5'd10, 5'd10, 1'b0, 32'h0, 32'h40);
    checks++; if (bus.AmuxBus !== 32'h40 || bus.BmuxBus !== 32'hFACECAFE) begin errors++; $display("FAIL read_pc got %h %h exp 00000040 facecafe", bus.AmuxBus, bus.BmuxBus); end
  endtask
  task automatic test_back_to_back();
    bus.rd_writeBus = 1; bus.rdOutBus = 5'd0; bus.result_outBus = 32'h55;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (bus.mem_ackBus) acks++;
    end
    bus.rd_writeBus = 0;
    step();
    checks++; if (acks !== 1) begin errors++; $display("FAIL held_strobe_acks got %0d exp 1", acks); end
    run_reg(0, 5'd0, 5'd0, 5'd0, 1'b1, 32'h0, 32'h0);
    checks++; if (bus.AmuxBus !== 32'h0 || rdy0 !== 1'b1) begin errors++; $display("FAIL reg0_read got %h rdy %b exp 00000000 rdy 1", bus.AmuxBus, rdy0); end
    bus.rd_writeBus = 1; bus.rdOutBus = 5'd5;
    run_mem(1, 32'h20, 32'h77);
    run_reg(0, 5'd0, 5'd5, 5'd0, 1'b1, 32'h0, 32'h0);
    checks++; if (bus.AmuxBus !== 32'h0) begin errors++; $display("FAIL priority_rd got %h exp 00000000", bus.AmuxBus); end
    run_mem(0, 32'h20, 32'h0);
    checks++; if (bus.memData !== 32'h77) begin errors++; $display("FAIL priority_mem got %h exp 00000077", bus.memData); end
  endtask
  task automatic test_reset_abort();
    run_mem(1, 32'h30, 32'h11111111);
    bus.mem_writeBus = 1; bus.mem_addressBus = 32'h30; bus.result_outBus = 32'h22222222;
    step();
    bus.mem_writeBus = 0;
    step();
    reset = 1;
    step();
    checks++; if (bus.grant !== 4'b0000 || bus.mem_ackBus !== 1'b0) begin errors++; $display("FAIL abort_state got %b ack %b exp 0000 ack 0", bus.grant, bus.mem_ackBus); end
    reset = 0;
    step();
    checks++; if (bus.grant !== 4'b0100) begin errors++; $display("FAIL abort_regrant got %b exp 0100", bus.grant); end
    run_mem(0, 32'h30, 32'h0);
    checks++; if (bus.memData !== 32'h11111111) begin errors++; $display("FAIL abort_word got %h exp 11111111", bus.memData); end
    run_reg(0, 5'd0, 5'd10, 5'd10, 1'b1, 32'h0, 32'h0);
    checks++; if (bus.AmuxBus !== 32'h0 || bus.BmuxBus !== 32'h0 || rdy0 !== 1'b1) begin errors++; $display("FAIL rf_cleared got %h %h exp 0 0", bus.AmuxBus, bus.BmuxBus); end
  endtask
  task automatic test_exec_done();
    bus.bus_request = 4'b1010;
    step(); step();
    checks++; if (bus.grant !== 4'b1000) begin errors++; $display("FAIL exec_grant3 got %b exp 1000", bus.grant); end
    bus.execution_completeBus = 1;
    step();
    bus.execution_completeBus = 0;
    checks++; if (bus.exec_done_mask !== 4'b1000) begin errors++; $display("FAIL exec_mask3 got %b exp 1000", bus.exec_done_mask); end
    bus.bus_request = 4'b0010;
    step(); step();
    checks++; if (bus.grant !== 4'b0010) begin errors++; $display("FAIL exec_grant1 got %b exp 0010", bus.grant); end
    bus.execution_completeBus = 1;
    step();
    bus.execution_completeBus = 0;
    bus.bus_request = 4'b0000;
    step();
    bus.execution_completeBus = 1;
    step();
    bus.execution_completeBus = 0;
    checks++; if (bus.exec_done_mask !== 4'b1010 || bus.all_done !== 1'b0) begin errors++; $display("FAIL exec_mask got %b/%b exp 1010/0", bus.exec_done_mask, bus.all_done); end
  endtask
  initial begin
    bus.bus_request = '0;
    bus.mem_addressBus = '0; bus.result_outBus = '0; bus.PCoutBus = '0;
    bus.rs1OutBus = '0; bus.rs2OutBus = '0; bus.rdOutBus = '0;
    bus.reg_selectBus = 0; bus.mem_readBus = 0; bus.mem_writeBus = 0;
    bus.rd_writeBus = 0; bus.read_enBus = 0; bus.execution_completeBus = 0;
    test_reset();
    test_arbitration();
    test_mem();
    test_out_of_range();
    test_regs();
    test_back_to_back();
    test_reset_abort();
    test_exec_done();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bus_controller.md
Name: bus_controller

Overview:
Bus-side responder for the PE bus interface in the RISC-V CGRA. Round-robin arbitrates bus_request from NUM_PE processing elements and drives a one-hot grant. It services the granted PE's shared-bus commands against an internal global data memory and a shared 32x32 register file. Responses return via mem_ackBus / memData / AmuxBus / BmuxBus / data_ReadyBus, and per-PE execution_complete reports are tracked.

Parameters:
NUM_PE, 4, number of requesting PEs (2..16)
MEM_WORDS, 256, global memory depth in 32-bit words (power of two); ADDR_W = log2(MEM_WORDS)
MEM_LATENCY, 2, wait cycles before a global read/write completes (>=1)
TIMEOUT_CYCLES, 64, idle-grant watchdog limit (optional feature only)

Ports:
clk  in  1  clock, single domain; all logic on posedge
reset  in  1  synchronous, active-high
bus_request  in  NUM_PE  per-PE request, bit i = PE i
grant  out  NUM_PE  one-hot grant, registered
mem_addressBus  in  32  byte address; index = [ADDR_W+1:2]; [1:0] ignored
result_outBus  in  32  write data (global mem or register)
PCoutBus  in  32  PC of granted PE, used as operand A when reg_selectBus=0
rs1OutBus / rs2OutBus / rdOutBus  in  5 each  register indices
reg_selectBus  in  1  1: A=reg[rs1]; 0: A=PCoutBus (B always reg[rs2])
mem_readBus / mem_writeBus / rd_writeBus / read_enBus  in  1 each  command strobes
execution_completeBus  in  1  granted PE reports completion
AmuxBus / BmuxBus  out  32 each  operand read results
memData  out  32  global read data
mem_ackBus  out  1  1-cycle pulse: mem read/write or rd_write done
data_ReadyBus  out  1  1-cycle pulse: AmuxBus/BmuxBus valid
bus_err  out  1  1-cycle pulse with ack on out-of-range global access
exec_done_mask  out  NUM_PE  sticky per-PE completion flags
all_done  out  1  &exec_done_mask

Behaviour:
- Reset: all outputs 0, state IDLE, RR pointer = NUM_PE-1 (PE0 wins first), memory contents unchanged, register file cleared to 0. Reset mid-operation aborts any pending write (memory unmodified).
- States: IDLE, GRANTED, MEM_WAIT, RESP, DRAIN.
- IDLE: any bus_request -> choose first set bit scanning from pointer+1 mod NUM_PE; grant bit set next edge, go GRANTED. Grant never changes while not IDLE.
- GRANTED: command priority mem_write > mem_read > rd_write > read_en; lower-priority strobes in the same cycle are ignored. If the granted PE's bus_request=0 and no strobe: grant cleared next edge, pointer = granted index, go IDLE.
- mem_write/mem_read: latch address/data, counter = MEM_LATENCY, go MEM_WAIT; counter reaching 0 -> write memory / load memData, go RESP; mem_ackBus high for exactly the RESP cycle. Read latency from strobe sample to ack = MEM_LATENCY+1 cycles.
- Out of range (addr[31:ADDR_W+2] != 0): write dropped, memData=0, bus_err pulses with mem_ackBus.
- rd_write: reg[rd]=result_outBus at sampling edge (rd=0 ignored); go RESP; mem_ackBus pulses next cycle.
- read_en: AmuxBus/BmuxBus registered at sampling edge (reg x0 reads 0); data_ReadyBus pulses next cycle. Write-then-read of the same register returns the new value.
- RESP -> DRAIN; DRAIN waits until all four strobes low, then GRANTED (4-phase handshake, no double execution).
- memData/AmuxBus/BmuxBus hold until next update.
- execution_completeBus high while in any non-IDLE state sets exec_done_mask[granted]; cleared only by reset.

Optional Feature:
BUS_TIMEOUT_EN: when defined, a counter runs in GRANTED with no strobe and resets on any strobe; on reaching TIMEOUT_CYCLES, grant is revoked (go IDLE, pointer = granted index) and sticky output timeout_err (1 bit, reset 0) is set. When undefined, there is no timeout_err port and a grant is held indefinitely while bus_request stays high.

Test Plan:
- Reset, bus_request=4'b0101 -> grant=4'b0001 next edge; PE0 drops request -> grant=4'b0100 within 2 cycles.
- Granted PE writes 0x12345678 to 0x00000010, MEM_LATENCY=2 -> mem_ackBus single pulse 3 cycles after strobe; later read of 0x10 -> memData=0x12345678 with ack.
- Write to 0xAABBCCDD (out of range) -> mem_ackBus and bus_err pulse together; memory unchanged; read returns memData=0.
- rd_write rd=10 data 0xFACECAFE, then read_en rs1=10, rs2=0, reg_select=1 -> AmuxBus=0xFACECAFE, BmuxBus=0, data_ReadyBus 1 cycle; reg_select=0, PCoutBus=0x40 -> AmuxBus=0x40.
- Strobe held high across RESP -> exactly one ack; rd_write rd=0 -> reg0 still reads 0.
- Reset asserted in MEM_WAIT of a write -> grant=0, no ack, target word unchanged; execution_completeBus from PE1 and PE3 -> exec_done_mask=4'b1010, all_done=0.
